// File: rtl/edge_frame_writer_pkg.sv
// ---------------------------------------------------------------------------
// edge_frame_writer_pkg
//
// Purpose:
//   Shared constants and types for the frame-buffer side of the edge-detection
//   pipeline. The display reader and the line buffer import the same package,
//   so raster geometry and the writer state encoding live in one place.
//
// Contents:
//   H_ACT, V_ACT    - active raster size (320x240)
//   FRAME_PIXELS    - pixels per frame (76800)
//   PIX_W           - pixel width (RGB444, 12 bits)
//   ADDR_W          - frame RAM address width (2^17 >= 76800)
//   fw_state_e      - writer FSM state encoding
//   ctrWidth()      - width of a counter that counts 0..n-1 (minimum 1 bit)
// ---------------------------------------------------------------------------
package edge_frame_writer_pkg;

  localparam int H_ACT        = 320;
  localparam int V_ACT        = 240;
  localparam int FRAME_PIXELS = H_ACT * V_ACT;
  localparam int PIX_W        = 12;
  localparam int ADDR_W       = 17;

  // IDLE waits for a start of frame, WRITE streams pixels into the current
  // bank, WAIT_SWAP holds a completed frame until the display reader frees
  // the other bank at vertical blank.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fw_state_e;

  // A one-entry range still needs one bit so the counter declaration is legal.
  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_frame_writer_pix_addr_counter.sv
// ---------------------------------------------------------------------------
// pix_addr_counter
//
// Purpose:
//   Raster position tracker for the frame writer. Holds the linear frame RAM
//   address of the next pixel to be written, together with x/y counters used
//   only to recognise the last pixel of the frame. The address is a plain
//   incrementer, so no y*H_ACT multiply is ever needed.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset, counters return to 0
//   clear_i  in   restart the raster at address 0
//   inc_i    in   advance one pixel (combined with clear_i: address 0 is
//                 being consumed this cycle, so the counter lands on 1)
//   addr_o   out  linear address of the next pixel, y*H_ACT + x
//   last_o   out  the next pixel is x=H_ACT-1, y=V_ACT-1
// ---------------------------------------------------------------------------
module pix_addr_counter #(
  parameter int H_ACT  = edge_frame_writer_pkg::H_ACT,
  parameter int V_ACT  = edge_frame_writer_pkg::V_ACT,
  parameter int ADDR_W = edge_frame_writer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  import edge_frame_writer_pkg::*;

  localparam int XW = ctrWidth(H_ACT);
  localparam int YW = ctrWidth(V_ACT);

  logic [ADDR_W-1:0] addr_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              lineEnd;
  logic              frameEnd;

  // End-of-line and end-of-frame are decoded from the current position so the
  // writer knows, while accepting a pixel, whether that pixel closes the frame.
  always_comb begin
    lineEnd  = (x_q == XW'(H_ACT - 1));
    frameEnd = (y_q == YW'(V_ACT - 1));
  end

  // Clear wins over a plain increment. When both are set the pixel at address
  // 0 is being written this cycle, so the counter moves straight to the
  // position that follows it. For a one-pixel-wide raster that is the start
  // of line 1 rather than x=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (clear_i) begin
      if (inc_i) begin
        addr_q <= ADDR_W'(1);
        x_q    <= (H_ACT > 1) ? XW'(1) : '0;
        y_q    <= (H_ACT > 1) ? '0 : YW'(1);
      end else begin
        addr_q <= '0;
        x_q    <= '0;
        y_q    <= '0;
      end
    end else if (inc_i) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (lineEnd) begin
        x_q <= '0;
        y_q <= frameEnd ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign addr_o = addr_q;
  assign last_o = lineEnd && frameEnd;

endmodule

// File: rtl/edge_frame_writer.sv
// ---------------------------------------------------------------------------
// edge_frame_writer
//
// Purpose:
//   Writes the filtered edge-detection pixel stream into a double-buffered
//   frame RAM. Tracks raster position, drives the RAM write port and swaps
//   banks with the display reader only at vertical blank, so the display
//   never scans a partially written frame. A frame that arrives while no bank
//   is free is dropped whole.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pixel_in    in   filtered pixel (PIX_W bits)
//   flag        in   pixel_in valid this cycle
//   sof         in   with flag: first pixel of a frame
//   vblank      in   one-cycle pulse at the start of display vertical blank
//   wr_en       out  frame RAM write strobe
//   wr_addr     out  linear write address y*H_ACT + x
//   wr_data     out  write data
//   wr_bank     out  bank being written
//   rd_bank     out  bank the display reads, always ~wr_bank
//   frame_done  out  pulse with the write of the last pixel of a frame
//   sync_err    out  pulse, sof arrived in the middle of a frame
//   frame_drop  out  pulse, a frame was discarded because no bank was free
//
// All outputs are registered and appear one cycle after the input cycle that
// caused them.
// ---------------------------------------------------------------------------
module edge_frame_writer #(
  parameter int H_ACT  = edge_frame_writer_pkg::H_ACT,
  parameter int V_ACT  = edge_frame_writer_pkg::V_ACT,
  parameter int PIX_W  = edge_frame_writer_pkg::PIX_W,
  parameter int ADDR_W = edge_frame_writer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              flag,
  input  logic              sof,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              sync_err,
  output logic              frame_drop
);

  import edge_frame_writer_pkg::*;

  fw_state_e         state_q;
  logic              wrEn_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [PIX_W-1:0]  wrData_q;
  logic              wrBank_q;
  logic              rdBank_q;
  logic              frameDone_q;
  logic              syncErr_q;
  logic              frameDrop_q;

  logic              startFrame;
  logic              advance;
  logic              cntClear;
  logic              cntInc;
  logic [ADDR_W-1:0] cntAddr;
  logic              cntLast;

  // Raster position of the next pixel to write.
  pix_addr_counter #(
    .H_ACT  (H_ACT),
    .V_ACT  (V_ACT),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cntClear),
    .inc_i   (cntInc),
    .addr_o  (cntAddr),
    .last_o  (cntLast)
  );

  // Counter steering. A start of frame (from IDLE, as a mid-frame resync, or
  // coinciding with the swap in WAIT_SWAP) writes address 0 and leaves the
  // counter on 1. A normal pixel advances the counter, except the closing
  // pixel which rewinds it to 0 for the next frame.
  always_comb begin
    startFrame = 1'b0;
    advance    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        startFrame = flag && sof;
      end
      ST_WRITE: begin
        startFrame = flag && sof;
        advance    = flag && !sof;
      end
      ST_WAIT_SWAP: begin
        startFrame = flag && sof && vblank;
      end
      default: begin
        startFrame = 1'b0;
      end
    endcase
    cntClear = startFrame || (advance && cntLast);
    cntInc   = startFrame || (advance && !cntLast);
  end

  // Writer FSM with registered outputs. Pulse outputs default low every cycle.
  // wr_addr and wr_data hold their last value between writes. The two bank
  // registers toggle together, which keeps rd_bank the complement of wr_bank
  // without a combinational inverter on an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      wrBank_q    <= 1'b0;
      rdBank_q    <= 1'b1;
      frameDone_q <= 1'b0;
      syncErr_q   <= 1'b0;
      frameDrop_q <= 1'b0;
    end else begin
      wrEn_q      <= 1'b0;
      frameDone_q <= 1'b0;
      syncErr_q   <= 1'b0;
      frameDrop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flag && sof) begin
            wrEn_q   <= 1'b1;
            wrAddr_q <= '0;
            wrData_q <= pixel_in;
            state_q  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (flag) begin
            wrEn_q   <= 1'b1;
            wrData_q <= pixel_in;
            if (sof) begin
              wrAddr_q  <= '0;
              syncErr_q <= 1'b1;
            end else begin
              wrAddr_q <= cntAddr;
              if (cntLast) begin
                frameDone_q <= 1'b1;
                state_q     <= ST_WAIT_SWAP;
              end
            end
          end
        end
        ST_WAIT_SWAP: begin
          if (vblank) begin
            wrBank_q <= ~wrBank_q;
            rdBank_q <= ~rdBank_q;
            if (flag && sof) begin
              wrEn_q   <= 1'b1;
              wrAddr_q <= '0;
              wrData_q <= pixel_in;
              state_q  <= ST_WRITE;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (flag && sof) begin
            frameDrop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign wr_bank    = wrBank_q;
  assign rd_bank    = rdBank_q;
  assign frame_done = frameDone_q;
  assign sync_err   = syncErr_q;
  assign frame_drop = frameDrop_q;

endmodule

// File: tb/tb_edge_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_edge_frame_writer
//
// Two writers share one input stream: dutFull at the default 320x240 raster
// and dutSmall at 16x8, so frame-completion cases that need several finished
// frames stay short. A frame-level reference model predicts every RAM write
// and every status pulse; a monitor compares what each writer presents.
// ---------------------------------------------------------------------------
module tb_edge_frame_writer;

  localparam int FULL_PIXELS  = 320 * 240;
  localparam int SMALL_H      = 16;
  localparam int SMALL_V      = 8;
  localparam int SMALL_PIXELS = SMALL_H * SMALL_V;
  localparam int EV_SYNC      = 1;
  localparam int EV_DROP      = 2;

  typedef struct {
    int         addr;
    logic [11:0] data;
    bit         bank;
    bit         done;
  } wrExp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] pixelIn;
  logic        flag;
  logic        sof;
  logic        vblank;

  logic        wrEn0, wrBank0, rdBank0, frameDone0, syncErr0, frameDrop0;
  logic [16:0] wrAddr0;
  logic [11:0] wrData0;
  logic        wrEn1, wrBank1, rdBank1, frameDone1, syncErr1, frameDrop1;
  logic [6:0]  wrAddr1;
  logic [11:0] wrData1;

  int checks = 0;
  int errors = 0;

  // Reference model: per writer, whether a frame is being written, whether a
  // finished frame awaits a free bank, the index of the next pixel and the
  // bank currently being filled.
  bit mBusy[2];
  bit mWait[2];
  bit mBank[2];
  int mIdx[2];
  int mSize[2];
  wrExp_t expQ0[$];
  wrExp_t expQ1[$];
  int evQ0[$];
  int evQ1[$];
  int wrSeen[2];

  edge_frame_writer dutFull (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_in   (pixelIn),
    .flag       (flag),
    .sof        (sof),
    .vblank     (vblank),
    .wr_en      (wrEn0),
    .wr_addr    (wrAddr0),
    .wr_data    (wrData0),
    .wr_bank    (wrBank0),
    .rd_bank    (rdBank0),
    .frame_done (frameDone0),
    .sync_err   (syncErr0),
    .frame_drop (frameDrop0)
  );

  edge_frame_writer #(
    .H_ACT  (SMALL_H),
    .V_ACT  (SMALL_V),
    .PIX_W  (12),
    .ADDR_W (7)
  ) dutSmall (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_in   (pixelIn),
    .flag       (flag),
    .sof        (sof),
    .vblank     (vblank),
    .wr_en      (wrEn1),
    .wr_addr    (wrAddr1),
    .wr_data    (wrData1),
    .wr_bank    (wrBank1),
    .rd_bank    (rdBank1),
    .frame_done (frameDone1),
    .sync_err   (syncErr1),
    .frame_drop (frameDrop1)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rndPix();
    return 12'($urandom);
  endfunction

  task automatic checkInt(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic pushWrite(input int k, input int a, input logic [11:0] d, input bit b, input bit done);
    wrExp_t e;
    e.addr = a;
    e.data = d;
    e.bank = b;
    e.done = done;
    if (k == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
  endtask

  task automatic pushEvent(input int k, input int code);
    if (k == 0) evQ0.push_back(code);
    else        evQ1.push_back(code);
  endtask

  task automatic startFrame(input int k, input logic [11:0] p);
    pushWrite(k, 0, p, mBank[k], mSize[k] == 1);
    mBusy[k] = (mSize[k] != 1);
    mWait[k] = (mSize[k] == 1);
    mIdx[k]  = 1;
  endtask

  // One input cycle of the frame-level behaviour for writer k.
  task automatic modelStep(input int k, input bit f, input bit s, input bit v, input logic [11:0] p);
    bit done;
    if (mWait[k]) begin
      if (v) begin
        mBank[k] = !mBank[k];
        mWait[k] = 1'b0;
        if (f && s) startFrame(k, p);
      end else if (f && s) begin
        pushEvent(k, EV_DROP);
      end
    end else if (mBusy[k]) begin
      if (f && s) begin
        pushEvent(k, EV_SYNC);
        startFrame(k, p);
      end else if (f) begin
        done = (mIdx[k] == mSize[k] - 1);
        pushWrite(k, mIdx[k], p, mBank[k], done);
        mIdx[k]++;
        if (done) begin
          mBusy[k] = 1'b0;
          mWait[k] = 1'b1;
        end
      end
    end else if (f && s) begin
      startFrame(k, p);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mBusy[k] = 1'b0;
      mWait[k] = 1'b0;
      mBank[k] = 1'b0;
      mIdx[k]  = 0;
    end
    expQ0.delete();
    expQ1.delete();
    evQ0.delete();
    evQ1.delete();
  endtask

  // Drive one cycle of inputs on the falling edge and record what it implies.
  task automatic applyStimulus(input bit f, input bit s, input bit v, input logic [11:0] p);
    @(negedge clk);
    flag    = f;
    sof     = s;
    vblank  = v;
    pixelIn = p;
    modelStep(0, f, s, v, p);
    modelStep(1, f, s, v, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rndPix());
  endtask

  // Reset values of both writers.
  task automatic checkOutput();
    checkInt("rst wr_en",      0, int'(wrEn0),      0);
    checkInt("rst wr_addr",    0, int'(wrAddr0),    0);
    checkInt("rst wr_data",    0, int'(wrData0),    0);
    checkInt("rst wr_bank",    0, int'(wrBank0),    0);
    checkInt("rst rd_bank",    0, int'(rdBank0),    1);
    checkInt("rst frame_done", 0, int'(frameDone0), 0);
    checkInt("rst sync_err",   0, int'(syncErr0),   0);
    checkInt("rst frame_drop", 0, int'(frameDrop0), 0);
    checkInt("rst wr_en",      1, int'(wrEn1),      0);
    checkInt("rst wr_addr",    1, int'(wrAddr1),    0);
    checkInt("rst wr_data",    1, int'(wrData1),    0);
    checkInt("rst wr_bank",    1, int'(wrBank1),    0);
    checkInt("rst rd_bank",    1, int'(rdBank1),    1);
    checkInt("rst frame_done", 1, int'(frameDone1), 0);
    checkInt("rst sync_err",   1, int'(syncErr1),   0);
    checkInt("rst frame_drop", 1, int'(frameDrop1), 0);
  endtask

  // Assert reset on a falling edge with the stream still running; the outputs
  // must already be at reset values 1 unit later.
  task automatic resetDut();
    @(negedge clk);
    rst_n  = 1'b0;
    flag   = 1'b0;
    sof    = 1'b0;
    vblank = 1'b0;
    modelReset();
    #1 checkOutput();
    repeat (2) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
  endtask

  task automatic checkInst(input int k, input bit en, input int addr, input logic [11:0] data,
                           input bit wb, input bit rb, input bit fd, input bit se, input bit fdrop);
    wrExp_t e;
    int     ev;
    int     act;
    checkInt("wr_bank", k, int'(wb), int'(mBank[k]));
    checkInt("rd_bank", k, int'(rb), int'(!mBank[k]));
    if (en) begin
      wrSeen[k]++;
      if ((k == 0 && expQ0.size() == 0) || (k == 1 && expQ1.size() == 0)) begin
        checkInt("unexpected wr_en", k, 1, 0);
      end else begin
        e = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
        checkInt("wr_addr",    k, addr,             e.addr);
        checkInt("wr_data",    k, int'(data),       int'(e.data));
        checkInt("write bank", k, int'(wb),         int'(e.bank));
        checkInt("frame_done", k, int'(fd),         int'(e.done));
      end
    end else begin
      checkInt("frame_done without write", k, int'(fd), 0);
    end
    if (se || fdrop) begin
      act = (se ? EV_SYNC : 0) + (fdrop ? EV_DROP : 0);
      if ((k == 0 && evQ0.size() == 0) || (k == 1 && evQ1.size() == 0)) begin
        checkInt("unexpected status pulse", k, act, 0);
      end else begin
        ev = (k == 0) ? evQ0.pop_front() : evQ1.pop_front();
        checkInt("status pulse", k, act, ev);
      end
    end
  endtask

  // Monitor: 1 unit after each rising edge, compare both writers against the
  // scoreboard and the model's bank state.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      checkInst(0, wrEn0, int'(wrAddr0), wrData0, wrBank0, rdBank0, frameDone0, syncErr0, frameDrop0);
      checkInst(1, wrEn1, int'(wrAddr1), wrData1, wrBank1, rdBank1, frameDone1, syncErr1, frameDrop1);
    end
  end

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run exceeded time limit, got no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int cnt;
    bit f;
    mSize[0]  = FULL_PIXELS;
    mSize[1]  = SMALL_PIXELS;
    wrSeen[0] = 0;
    wrSeen[1] = 0;
    rst_n   = 1'b0;
    flag    = 1'b0;
    sof     = 1'b0;
    vblank  = 1'b0;
    pixelIn = '0;
    modelReset();
    repeat (3) @(negedge clk);
    #1 checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] full frame, pixel = address[11:0]");
    applyStimulus(1'b1, 1'b1, 1'b0, 12'd0);
    for (int i = 1; i < FULL_PIXELS; i++) applyStimulus(1'b1, 1'b0, 1'b0, 12'(i));
    idle(4);

    $display("[TB] frame arriving with no free bank");
    applyStimulus(1'b1, 1'b1, 1'b0, rndPix());
    for (int i = 0; i < 120; i++) applyStimulus($urandom_range(0, 3) != 0, 1'b0, 1'b0, rndPix());

    $display("[TB] vblank swap while the dropped frame keeps streaming");
    applyStimulus(1'b1, 1'b0, 1'b1, rndPix());
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b0, 1'b0, rndPix());
    idle(3);

    $display("[TB] second frame with resync at pixel 1000, reset at pixel 5000");
    applyStimulus(1'b1, 1'b1, 1'b0, rndPix());
    cnt = 1;
    while (cnt < 1000) begin
      f = ($urandom_range(0, 4) != 0);
      applyStimulus(f, 1'b0, cnt == 400, rndPix());
      if (f) cnt++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, rndPix());
    cnt++;
    while (cnt < 5000) begin
      f = ($urandom_range(0, 4) != 0);
      applyStimulus(f, 1'b0, 1'b0, rndPix());
      if (f) cnt++;
    end
    resetDut();

    $display("[TB] pixels without sof after reset");
    wrSeen[0] = 0;
    wrSeen[1] = 0;
    for (int i = 0; i < 40; i++) applyStimulus($urandom_range(0, 1) != 0, 1'b0, 1'b0, rndPix());
    idle(2);
    checkInt("writes after reset", 0, wrSeen[0], 0);
    checkInt("writes after reset", 1, wrSeen[1], 0);

    $display("[TB] vblank and sof in the same cycle");
    applyStimulus(1'b1, 1'b1, 1'b0, rndPix());
    for (int i = 1; i < SMALL_PIXELS; i++) applyStimulus(1'b1, 1'b0, 1'b0, rndPix());
    idle(3);
    applyStimulus(1'b1, 1'b1, 1'b1, rndPix());
    for (int i = 0; i < 200; i++) applyStimulus($urandom_range(0, 3) != 0, 1'b0, 1'b0, rndPix());
    idle(3);

    checkInt("pending writes", 0, expQ0.size(), 0);
    checkInt("pending writes", 1, expQ1.size(), 0);
    checkInt("pending pulses", 0, evQ0.size(), 0);
    checkInt("pending pulses", 1, evQ1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
